// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer.
// Holds the state encoding, bus_src_oh bit positions, the legal opcode
// window, the instruction field positions and the latched-field struct.
package bus_sequencer_pkg;

  localparam int ST_W = 4;

  // State encoding
  localparam logic [ST_W-1:0] ST_IDLE = 4'd0;
  localparam logic [ST_W-1:0] ST_T0   = 4'd1;
  localparam logic [ST_W-1:0] ST_T1   = 4'd2;
  localparam logic [ST_W-1:0] ST_T2   = 4'd3;
  localparam logic [ST_W-1:0] ST_T3   = 4'd4;
  localparam logic [ST_W-1:0] ST_T4   = 4'd5;
  localparam logic [ST_W-1:0] ST_T5   = 4'd6;
  localparam logic [ST_W-1:0] ST_T6   = 4'd7;
  localparam logic [ST_W-1:0] ST_HALT = 4'd8;

  // bus_src_oh bit positions; bits 0..15 are R0..R15
  localparam int SRC_W      = 24;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Legal opcode window (add .. rol)
  localparam logic [4:0] OP_MIN = 5'h03;
  localparam logic [4:0] OP_MAX = 5'h0B;

  // ir field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } fields_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op >= OP_MIN) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/bus_sequencer_onehot16_decode.sv
// 4-bit index to 16-bit one-hot decoder with enable.
// Ports: en (decoder enable), idx (bit to set), oh (one-hot result, 0 when en=0).
module onehot16_decode (
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] oh
);

  always_comb begin
    oh = '0;
    if (en) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Moore control sequencer for a single-bus datapath.
// Steps fetch (T0..T2), decode (T3) and a three-cycle ALU execute (T4..T6).
// Ports: clock/reset_n (async active-low), run, mem_ready, ir (inputs);
// bus_src_oh (one-hot bus driver select), reg_in (one-hot register load),
// pc_in/ir_in/mar_in/mdr_in/y_in/z_in/inc_pc/read strobes, alu_op,
// done (completion pulse), illegal (sticky bad-opcode flag).
module bus_sequencer
  import bus_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic [SRC_W-1:0] bus_src_oh,
  output logic [15:0]      reg_in,
  output logic             pc_in,
  output logic             ir_in,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             y_in,
  output logic             z_in,
  output logic             inc_pc,
  output logic             read,
  output logic [4:0]       alu_op,
  output logic             done,
  output logic             illegal
);

  logic [ST_W-1:0] state_q, state_d;
  fields_t         fld_q;
  logic            illegal_q;
  logic [15:0]     reg_src;
  logic            src_en;
  logic [3:0]      src_idx;
  logic            dst_en;
  logic            unused_ir;

  // Low ir bits carry no control meaning here.
  assign unused_ir = ^ir[RC_LSB-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = op_legal(ir[OP_MSB:OP_LSB]) ? ST_T4 : ST_HALT;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and latched fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      fld_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T3) begin
        fld_q.op <= ir[OP_MSB:OP_LSB];
        fld_q.ra <= ir[RA_MSB:RA_LSB];
        fld_q.rb <= ir[RB_MSB:RB_LSB];
        fld_q.rc <= ir[RC_MSB:RC_LSB];
        if (!op_legal(ir[OP_MSB:OP_LSB])) illegal_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register decoders: one shared decoder selects Rb (T4) or Rc (T5) onto
  // the bus, the other drives the destination load in T6.
  // ---------------------------------------------------------------------------
  assign src_en  = (state_q == ST_T4) || (state_q == ST_T5);
  assign src_idx = (state_q == ST_T4) ? fld_q.rb : fld_q.rc;
  assign dst_en  = (state_q == ST_T6);

  onehot16_decode u_src_dec (
    .en  (src_en),
    .idx (src_idx),
    .oh  (reg_src)
  );

  onehot16_decode u_dst_dec (
    .en  (dst_en),
    .idx (fld_q.ra),
    .oh  (reg_in)
  );

  // ---------------------------------------------------------------------------
  // Moore outputs. Register sources are only non-zero in T4/T5, where no
  // other source is driven, so bus_src_oh stays zero-or-one-hot.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_src_oh       = '0;
    bus_src_oh[15:0] = reg_src;
    pc_in            = 1'b0;
    ir_in            = 1'b0;
    mar_in           = 1'b0;
    mdr_in           = 1'b0;
    y_in             = 1'b0;
    z_in             = 1'b0;
    inc_pc           = 1'b0;
    read             = 1'b0;
    alu_op           = '0;
    done             = 1'b0;
    case (state_q)
      ST_T0: begin
        bus_src_oh[SRC_PC] = 1'b1;
        mar_in             = 1'b1;
        inc_pc             = 1'b1;
        z_in               = 1'b1;
      end
      ST_T1: begin
        bus_src_oh[SRC_ZLO] = 1'b1;
        pc_in               = 1'b1;
        read                = 1'b1;
        mdr_in              = 1'b1;
      end
      ST_T2: begin
        bus_src_oh[SRC_MDR] = 1'b1;
        ir_in               = 1'b1;
      end
      ST_T4: y_in = 1'b1;
      ST_T5: begin
        z_in   = 1'b1;
        alu_op = fld_q.op;
      end
      ST_T6: begin
        bus_src_oh[SRC_ZLO] = 1'b1;
        done                = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: per-cycle output vectors against
// hand-derived expectations, plus a randomized one-hot sweep.
module tb_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic [23:0] bus_src_oh;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, read;
  logic [4:0]  alu_op;
  logic        done;
  logic        illegal;
  logic [54:0] obs;

  int checks   = 0;
  int failures = 0;

  localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4,
                 S_T4 = 5, S_T5 = 6, S_T6 = 7, S_HALT = 8;

  bus_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .mem_ready  (mem_ready),
    .ir         (ir),
    .bus_src_oh (bus_src_oh),
    .reg_in     (reg_in),
    .pc_in      (pc_in),
    .ir_in      (ir_in),
    .mar_in     (mar_in),
    .mdr_in     (mdr_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .inc_pc     (inc_pc),
    .read       (read),
    .alu_op     (alu_op),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  // {bus_src_oh, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, read, alu_op, done, illegal}
  assign obs = {bus_src_oh, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                inc_pc, read, alu_op, done, illegal};

  // Expected output vector per state, written from the state table.
  function automatic logic [54:0] exp_out(input int st, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc,
                                          input logic [4:0] op);
    logic [23:0] src;
    logic [15:0] rin;
    logic [7:0]  stb;
    logic [4:0]  alu;
    logic        dn;
    logic        ill;
    src = '0; rin = '0; stb = '0; alu = '0; dn = 1'b0; ill = 1'b0;
    case (st)
      S_T0:   begin src[20] = 1'b1; stb = 8'h26; end  // PC; mar_in, z_in, inc_pc
      S_T1:   begin src[19] = 1'b1; stb = 8'h91; end  // Zlow; pc_in, mdr_in, read
      S_T2:   begin src[21] = 1'b1; stb = 8'h40; end  // MDR; ir_in
      S_T4:   begin src[rb] = 1'b1; stb = 8'h08; end  // Rb; y_in
      S_T5:   begin src[rc] = 1'b1; stb = 8'h04; alu = op; end
      S_T6:   begin src[19] = 1'b1; rin[ra] = 1'b1; dn = 1'b1; end
      S_HALT: ill = 1'b1;
      default: ;
    endcase
    return {src, rin, stb, alu, dn, ill};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [54:0] e;
    reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'h1A988000;
    #1;
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL reset_initial got=%h exp=%h", obs, 55'd0);
    end
    @(negedge clock); @(negedge clock);
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL reset_held got=%h exp=%h", obs, 55'd0);
    end
    // release with run low: stays idle
    run = 1'b0; reset_n = 1'b1;
    @(negedge clock); @(negedge clock);
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL idle_no_run got=%h exp=%h", obs, 55'd0);
    end
    // first edge after release takes the IDLE transition
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1; run = 1'b1;
    @(negedge clock);
    e = exp_out(S_T0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL first_edge_t0 got=%h exp=%h", obs, e);
    end
  endtask

  // add R5 <- R3 + R1, then back-to-back rol-style op 0x0A R15 <- R0, R14
  task automatic test_add_back_to_back();
    int seq [14] = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
                     S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6};
    logic [54:0] e;
    do_reset();
    ir = 32'h1A988000; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (i < 7) e = exp_out(seq[i], 4'd5, 4'd3, 4'd1, 5'h03);
      else       e = exp_out(seq[i], 4'd15, 4'd0, 4'd14, 5'h0A);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL add_b2b cyc=%0d got=%h exp=%h", i + 1, obs, e);
      end
      if (i == 6)  ir = {5'h0A, 4'd15, 4'd0, 4'd14, 15'd0};
      if (i == 13) run = 1'b0;
    end
    @(negedge clock);
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL add_b2b_idle got=%h exp=%h", obs, 55'd0);
    end
  endtask

  // sub R0 <- R15 - R7 with four stall cycles in T1
  task automatic test_stall();
    int seq [11] = '{S_T0, S_T1, S_T1, S_T1, S_T1, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6};
    logic [54:0] e;
    do_reset();
    ir = {5'h04, 4'd0, 4'd15, 4'd7, 15'd0}; run = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      e = exp_out(seq[i], 4'd0, 4'd15, 4'd7, 5'h04);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL stall cyc=%0d got=%h exp=%h", i + 1, obs, e);
      end
      if (i == 5)  mem_ready = 1'b1;
      if (i == 10) run = 1'b0;
    end
    @(negedge clock);
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL stall_idle got=%h exp=%h", obs, 55'd0);
    end
  endtask

  task automatic test_illegal();
    int seq [4] = '{S_T0, S_T1, S_T2, S_T3};
    logic [54:0] e;
    do_reset();
    ir = {5'h1F, 27'h5A5A5A5}; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      e = exp_out(seq[i], 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL illegal_fetch cyc=%0d got=%h exp=%h", i + 1, obs, e);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      e = exp_out(S_HALT, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL illegal_halt cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL illegal_reset got=%h exp=%h", obs, 55'd0);
    end
    @(negedge clock);
    reset_n = 1'b1; run = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL illegal_after_reset got=%h exp=%h", obs, 55'd0);
    end
  endtask

  // opcodes just outside the legal window must halt
  task automatic test_opcode_bounds();
    logic [4:0] ops [2] = '{5'h02, 5'h0C};
    logic [54:0] e;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      ir = {ops[k], 4'd1, 4'd2, 4'd3, 15'd0}; run = 1'b1; mem_ready = 1'b1;
      repeat (5) @(negedge clock);
      e = exp_out(S_HALT, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL opcode_bound op=%h got=%h exp=%h", ops[k], obs, e);
      end
    end
  endtask

  // rol R9 <- R2, R12 with run dropped in T2
  task automatic test_run_drop();
    int seq [10] = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_IDLE, S_IDLE, S_IDLE};
    logic [54:0] e;
    do_reset();
    ir = {5'h0B, 4'd9, 4'd2, 4'd12, 15'd0}; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      e = exp_out(seq[i], 4'd9, 4'd2, 4'd12, 5'h0B);
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL run_drop cyc=%0d got=%h exp=%h", i + 1, obs, e);
      end
      if (i == 2) run = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [54:0] e;
    do_reset();
    ir = 32'h1A988000; run = 1'b1; mem_ready = 1'b1;
    repeat (6) @(negedge clock);
    e = exp_out(S_T5, 4'd5, 4'd3, 4'd1, 5'h03);
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL async_pre_t5 got=%h exp=%h", obs, e);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL async_t5 got=%h exp=%h", obs, 55'd0);
    end
    @(negedge clock);
    reset_n = 1'b1; run = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL async_t5_idle got=%h exp=%h", obs, 55'd0);
    end
    // reset during a T1 stall
    run = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    e = exp_out(S_T1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL async_pre_stall got=%h exp=%h", obs, e);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 55'd0) begin
      failures++; $display("FAIL async_stall got=%h exp=%h", obs, 55'd0);
    end
    @(negedge clock);
    reset_n = 1'b1; run = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_random_onehot();
    int shown = 0;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      checks++;
      if ($countones(bus_src_oh) > 1 || $countones(reg_in) > 1) begin
        failures++;
        if (shown < 10)
          $display("FAIL onehot cyc=%0d src=%h reg_in=%h exp=zero_or_onehot", i, bus_src_oh, reg_in);
        shown++;
      end
      run       = ($urandom_range(0, 9) != 0);
      mem_ready = 1'($urandom_range(0, 1));
      ir        = {5'($urandom_range(1, 13)), 27'($urandom)};
      reset_n   = ((i % 97) != 96);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
    test_reset();
    test_add_back_to_back();
    test_stall();
    test_illegal();
    test_opcode_bounds();
    test_run_drop();
    test_async_reset();
    test_random_onehot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
